set_duty_ramp: RTL and testbench
================================

# set_duty_ramp

Slew-rate limiter for a PWM duty command. It moves a registered duty value toward a requested target by at most a programmable step, once every fixed number of clocks. This keeps PWM/motor stages from seeing abrupt duty jumps. It sits between the control logic that produces `duty_need` and the PWM generator that consumes `duty_out`.

## Interface
- `STEP_CYCLES`, default 100: clocks between ramp updates; legal values are 1 to 2^16.
- `DUTY_W`, default 20: duty width.
- `GAP_W`, default 10: step-size width.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  input  1: rising-edge system clock.
- `rst_n`  input  1: asynchronous active-low reset.
- `duty_need`  input  DUTY_W: target duty, unsigned.
- `duty_gap`  input  GAP_W: maximum change per update, unsigned.
- `duty_out`  output  DUTY_W: ramped duty, registered, unsigned.

## Operation
- A free-running tick counter counts 0 to STEP_CYCLES-1 and wraps.
- `tick` is asserted in the cycle where the count equals STEP_CYCLES-1.
- On a tick edge, with gap = zero-extended `duty_gap`:
  - out < need: if need-out ≤ gap, then out ← need; otherwise out ← out+gap.
  - out > need: if out-need ≤ gap, then out ← need; otherwise out ← out-gap.
  - out = need: hold.
- Between ticks, `duty_out` holds.
- Differences are computed in DUTY_W bits only when positive, so arithmetic never wraps. `duty_out` cannot overshoot `duty_need` and cannot leave the range 0 to 2^DUTY_W-1.
- `duty_gap` = 0: `duty_out` freezes at its current value.
- `duty_need` and `duty_gap` are sampled only on the tick edge. Changes between ticks have no effect until the next tick. A target change mid-ramp redirects the ramp from the current value.
- No handshake. The inputs are static-level commands.

## Timing
- Reset values: `duty_out` = 0, tick counter = 0.
- Reset assertion clears both immediately, independent of `clk`, including in the middle of a ramp.
- After reset release, the first update occurs on the STEP_CYCLES-th rising edge. Subsequent updates occur every STEP_CYCLES edges.
- Latency from a `duty_need` change to the first `duty_out` movement: 1 to STEP_CYCLES clocks.
- Full slew time is ceil(|need-out| / gap) × STEP_CYCLES clocks.
- `duty_out` changes only on clock edges and comes directly from a flop, with no combinational path from inputs.
- STEP_CYCLES = 1: the block updates every clock.

## Structure
- Shared package `set_duty_pkg` holds:
  - `DUTY_W` and `GAP_W` default constants.
  - `duty_t` typedef (logic [DUTY_W-1:0]).
  - `gap_t` typedef (logic [GAP_W-1:0]).
- Sub-module `tick_div`: parameterised STEP_CYCLES counter with async active-low reset, outputting the one-cycle `tick`.
- The top level holds the compare/step/clamp datapath and the `duty_out` register.

## Test plan
- Reset: hold `rst_n` = 0 with need=100, gap=10.
  - Required: `duty_out` = 0 throughout reset and for 99 clocks after release.
- Ramp up: need=100, gap=10.
  - Required: out = 10 after 100 clocks, 20 after 200, …, 100 after 1000 clocks, then holds at 100 through clock 1200.
- Ramp down: then need=50.
  - Required: out steps 90, 80, 70, 60, 50, one step per 100 clocks, then holds at 50.
- Clamp, non-multiple step: out=0, need=100, gap=30.
  - Required: out goes 30, 60, 90, then 100 (never exceeds 100).
  - Then need=95, gap=30: out goes straight to 95.
- Freeze and async reset mid-ramp:
  - gap=0 mid-ramp: out stays constant.
  - `rst_n` pulsed low between clock edges: out = 0 immediately, and the ramp restarts from 0 with full STEP_CYCLES latency.
- Extremes: need=0xFFFFF, gap=1023.
  - Required: out reaches 0xFFFFF with no wrap.
  - Then need=0: out descends to 0 with no underflow.

Source files
------------

// File: rtl/set_duty_pkg.sv
// Shared widths and duty/gap types for the duty-ramp slew limiter.
package set_duty_pkg;

    localparam int unsigned DEFAULT_DUTY_W = 20;
    localparam int unsigned DEFAULT_GAP_W  = 10;

    typedef logic [DEFAULT_DUTY_W-1:0] duty_t;
    typedef logic [DEFAULT_GAP_W-1:0]  gap_t;

endpackage

// File: rtl/tick_div.sv
// Free-running 0..STEP_CYCLES-1 counter with a one-cycle tick on the last count.
module tick_div #(
    parameter int unsigned STEP_CYCLES = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    // Keep at least one bit so STEP_CYCLES = 1 still elaborates; the tick is then constant.
    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/set_duty_ramp.sv
// Slew-rate limiter: steps duty_out toward duty_need by at most duty_gap once per tick.
module set_duty_ramp
    import set_duty_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 100,
    parameter int unsigned DUTY_W      = DEFAULT_DUTY_W,
    parameter int unsigned GAP_W       = DEFAULT_GAP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty_need,
    input  logic [GAP_W-1:0]  duty_gap,
    output logic [DUTY_W-1:0] duty_out
);

    logic              tick;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] gap_ext;
    logic [DUTY_W-1:0] diff;

    tick_div #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_tick_div (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign gap_ext = DUTY_W'(duty_gap);

    // Differences are only taken in the positive direction, and a step is only
    // applied when it is strictly smaller than the distance, so nothing wraps.
    always_comb begin
        duty_d = duty_q;
        diff   = '0;
        if (tick) begin
            if (duty_q < duty_need) begin
                diff   = duty_need - duty_q;
                duty_d = (diff <= gap_ext) ? duty_need : duty_q + gap_ext;
            end else if (duty_q > duty_need) begin
                diff   = duty_q - duty_need;
                duty_d = (diff <= gap_ext) ? duty_need : duty_q - gap_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_out = duty_q;

endmodule

// File: tb/tb_set_duty_ramp.sv
// Directed bench for set_duty_ramp: STEP_CYCLES=100 instance plus a STEP_CYCLES=1 instance for extremes.
module tb_set_duty_ramp;
    import set_duty_pkg::*;

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst_n;
    duty_t duty_need;
    gap_t  duty_gap;
    duty_t duty_out;

    logic  rst1_n;
    duty_t need1;
    gap_t  gap1;
    duty_t out1;

    int checks = 0;
    int errors = 0;

    set_duty_ramp #(
        .STEP_CYCLES(100),
        .DUTY_W     (DEFAULT_DUTY_W),
        .GAP_W      (DEFAULT_GAP_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .duty_need(duty_need),
        .duty_gap (duty_gap),
        .duty_out (duty_out)
    );

    set_duty_ramp #(
        .STEP_CYCLES(1),
        .DUTY_W     (DEFAULT_DUTY_W),
        .GAP_W      (DEFAULT_GAP_W)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst1_n),
        .duty_need(need1),
        .duty_gap (gap1),
        .duty_out (out1)
    );

    task automatic check(input string tag, input duty_t obs, input duty_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each wait ends on a falling edge, half a period away from the active edge.
    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; reset is asserted and released before the next rising edge.
    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", duty_out, '0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        duty_need = 100;
        duty_gap  = 10;
        rst1_n    = 1'b0;
        need1     = 20'hFFFFF;
        gap1      = 10'd1023;

        // Reset and first-update latency
        clocks(3);
        check("reset_hold", duty_out, '0);
        check("reset_hold_s1", out1, '0);
        rst_n = 1'b1;
        clocks(99);
        check("before_first_tick", duty_out, '0);
        clocks(1);
        check("ramp_up_1", duty_out, 20'd10);
        for (int k = 2; k <= 10; k++) begin
            clocks(100);
            check($sformatf("ramp_up_%0d", k), duty_out, duty_t'(10 * k));
        end
        clocks(200);
        check("hold_at_100", duty_out, 20'd100);

        // Ramp down toward 50
        duty_need = 50;
        for (int k = 1; k <= 5; k++) begin
            clocks(100);
            check($sformatf("ramp_down_%0d", k), duty_out, duty_t'(100 - 10 * k));
        end
        clocks(200);
        check("hold_at_50", duty_out, 20'd50);

        // Clamp on a non-multiple step
        duty_need = 100;
        duty_gap  = 30;
        rst_pulse();
        clocks(99);
        check("clamp_latency", duty_out, '0);
        clocks(1);
        check("clamp_30", duty_out, 20'd30);
        clocks(100);
        check("clamp_60", duty_out, 20'd60);
        clocks(100);
        check("clamp_90", duty_out, 20'd90);
        clocks(100);
        check("clamp_100", duty_out, 20'd100);
        clocks(100);
        check("clamp_no_overshoot", duty_out, 20'd100);
        duty_need = 95;
        clocks(100);
        check("clamp_down_95", duty_out, 20'd95);

        // Freeze with gap=0, then async reset mid-ramp
        duty_need = 1000;
        duty_gap  = 10;
        rst_pulse();
        clocks(300);
        check("freeze_pre", duty_out, 20'd30);
        duty_gap = 0;
        clocks(300);
        check("freeze_hold", duty_out, 20'd30);
        duty_gap = 10;
        clocks(100);
        check("freeze_resume", duty_out, 20'd40);
        clocks(50);
        rst_pulse();
        clocks(99);
        check("restart_latency", duty_out, '0);
        clocks(1);
        check("restart_first_step", duty_out, 20'd10);

        // Extremes on the STEP_CYCLES=1 instance
        rst1_n = 1'b1;
        clocks(1);
        check("ext_up_1", out1, 20'd1023);
        clocks(1);
        check("ext_up_2", out1, 20'd2046);
        clocks(1022);
        check("ext_up_1024", out1, 20'd1047552);
        clocks(1);
        check("ext_up_top", out1, 20'hFFFFF);
        clocks(5);
        check("ext_top_hold", out1, 20'hFFFFF);
        need1 = '0;
        clocks(1);
        check("ext_down_1", out1, 20'd1047552);
        clocks(1023);
        check("ext_down_1024", out1, 20'd1023);
        clocks(1);
        check("ext_down_zero", out1, '0);
        clocks(5);
        check("ext_zero_hold", out1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
